mem_stage_ls: RTL and testbench
===============================

# mem_stage_ls

MEM-stage local-store responder for the dual-issue SPU pipeline. Consumes the two EX/MEM lanes (control, 128-bit result, 7-bit RT) and services load/store requests against a quadword-organised local store. Drives the MEM/WB register for both lanes. When both lanes request memory in the same cycle, it serialises them over two cycles and stalls upstream.

## Interface
- LS_DEPTH, 2048: local-store depth in quadwords (32 KB); power of two.
- ADDR_W, $clog2(LS_DEPTH): quadword index width.
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- memToReg_MEM1/2, regWriteEnable_MEM1/2, memRead_MEM1/2, memWrite_MEM1/2  in  1 each  lane controls from EX/MEM.
- result_MEM1/2  in  128  ALU result; bits [127:96] (preferred slot) are the byte address for memory ops.
- registerRT_MEM1/2  in  7  destination/store-source register index.
- storeData_MEM1/2  in  128  quadword to store.
- stall_MEM  out  1  combinational; upstream holds EX/MEM contents while high.
- result_WB1/2  out  128  registered lane result or load data.
- registerRT_WB1/2  out  7  registered RT.
- regWriteEnable_WB1/2  out  1  registered write enable; 0 marks a bubble.
- ls_err  out  1  sticky address-range error (only with LS_ERR_EN; otherwise tied 0).

## Operation
- A lane is a memory op when memRead or memWrite is high. Quadword index = addr[ADDR_W+3:4]. addr[3:0] is ignored, so all accesses are quadword aligned.
- States: IDLE, SECOND.
- IDLE, fewer than two memory ops:
  - Each lane is processed independently.
  - Memory ops use the single array port; only one lane can be a memory op here.
  - Stall_MEM = 0.
- IDLE, both lanes are memory ops:
  - Lane 1 accesses the array. WB1 is loaded normally.
  - WB2 is written as a bubble: regWriteEnable_WB2 = 0, result_WB2 = 0, registerRT_WB2 = 0.
  - stall_MEM = 1; next state is SECOND.
- SECOND:
  - Lane 2 (inputs held by upstream) accesses the array. WB2 is loaded normally.
  - WB1 is written as a bubble.
  - stall_MEM = 0; next state is IDLE.
- Lane 1 is always the older instruction. Serialising lane 1 before lane 2 preserves program order for same-address store/load and store/store pairs (lane 2's store lands last).
- WB result mux: result_WB = memToReg ? array read data : result_MEM.
  - Stores write storeData at the index at the clock edge.
  - Stores propagate regWriteEnable unchanged; the decoder keeps it 0 for stores.
- memRead and memWrite both high on one lane: the write is performed, and the load data returned is the pre-write contents (read-before-write).
- Array contents are not reset and are undefined after power-up.

## Timing
- Reset (reset low, async):
  - All WB outputs = 0 and ls_err = 0; state = IDLE; stall_MEM = 0.
  - A pending SECOND access is dropped.
- Latency: one cycle from MEM inputs to WB outputs for every lane, including loads. The array read is synchronous and captured at the same edge as the WB register.
- Dual-memory-op pair: WB1 valid at edge N+1, WB2 valid at edge N+2. Exactly one stall cycle.
- Back-to-back dual pairs: IDLE→SECOND→IDLE→SECOND. Each pair costs two cycles; there is no extra bubble between pairs.
- stall_MEM depends only on state and the current memRead/memWrite inputs. It has no combinational path from array data.

## Configuration
- LS_ERR_EN defined:
  - An address with nonzero bits above ADDR_W+3 is out of range.
  - Out-of-range stores are suppressed, and out-of-range loads return 0.
  - ls_err sets on the edge that processes the op and stays set until reset.
- LS_ERR_EN undefined: upper address bits are ignored (wrap-around modulo LS_DEPTH), and ls_err is tied 0.

## Structure
- spu_pkg: QW_W = 128, REG_ADDR_W = 7, ls_state_t enum {IDLE, SECOND}, the WB lane struct (result, rt, we).
- Sub-module ls_ram:
  - Single-port LS_DEPTH × 128 array.
  - Synchronous write; synchronous read-before-write.
  - Enable input.
- mem_stage_ls holds the FSM, port mux, error check, and WB registers.

## Test plan
- Reset low mid-SECOND → all WB outputs 0, stall_MEM 0, state IDLE. After release, lane 2's store at 0x40 has not been performed.
- Lane 1 store 0x0000_0010 data 0xA5…A5, then next cycle lane 2 load 0x0000_001C (memToReg = 1, RT = 5) → result_WB2 = 0xA5…A5 and registerRT_WB2 = 5, one cycle later.
- Both lanes in one cycle: lane 1 store 0x20 data 0x1111…, lane 2 load 0x20 → stall_MEM high for exactly one cycle. WB1 written then WB2 = 0x1111… the next cycle; WB1 is a bubble in the second cycle.
- Lane 1 add (result 0x7, RT = 3, WE = 1) alongside lane 2 load → no stall; both WB written on the same edge.
- Both lanes store to 0x30 (0xAA…, then 0xBB…), then load 0x30 → 0xBB….
- With LS_ERR_EN, LS_DEPTH = 2048: store to 0x0001_0000 → no array change, ls_err = 1 and sticky. Without the macro, the same store writes index 0.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared types for the SPU MEM stage: quadword/register widths, the local-store
// FSM state and the MEM/WB lane record.
package spu_pkg;

  localparam int QW_W       = 128;
  localparam int REG_ADDR_W = 7;
  localparam int BYTE_ADDR_W = 32;

  typedef enum logic {
    IDLE,
    SECOND
  } ls_state_t;

  typedef struct packed {
    logic [QW_W-1:0]       result;
    logic [REG_ADDR_W-1:0] rt;
    logic                  we;
  } wb_lane_t;

  // Any set bit above the quadword index means the byte address is past the store.
  function automatic logic addr_oor(input logic [BYTE_ADDR_W-1:0] byte_addr,
                                    input int unsigned addr_w);
    return (byte_addr >> (addr_w + 4)) != '0;
  endfunction

endpackage

// File: rtl/mem_stage_ls_if.sv
// EX/MEM lane inputs, stall and MEM/WB outputs of the local-store MEM stage.
interface mem_stage_ls_if
  import spu_pkg::*;
();

  logic                  memToReg_MEM1, memToReg_MEM2;
  logic                  regWriteEnable_MEM1, regWriteEnable_MEM2;
  logic                  memRead_MEM1, memRead_MEM2;
  logic                  memWrite_MEM1, memWrite_MEM2;
  logic [QW_W-1:0]       result_MEM1, result_MEM2;
  logic [REG_ADDR_W-1:0] registerRT_MEM1, registerRT_MEM2;
  logic [QW_W-1:0]       storeData_MEM1, storeData_MEM2;

  logic                  stall_MEM;
  logic [QW_W-1:0]       result_WB1, result_WB2;
  logic [REG_ADDR_W-1:0] registerRT_WB1, registerRT_WB2;
  logic                  regWriteEnable_WB1, regWriteEnable_WB2;
  logic                  ls_err;

  modport master (
    output memToReg_MEM1, memToReg_MEM2, regWriteEnable_MEM1, regWriteEnable_MEM2,
           memRead_MEM1, memRead_MEM2, memWrite_MEM1, memWrite_MEM2,
           result_MEM1, result_MEM2, registerRT_MEM1, registerRT_MEM2,
           storeData_MEM1, storeData_MEM2,
    input  stall_MEM, result_WB1, result_WB2, registerRT_WB1, registerRT_WB2,
           regWriteEnable_WB1, regWriteEnable_WB2, ls_err
  );

  modport slave (
    input  memToReg_MEM1, memToReg_MEM2, regWriteEnable_MEM1, regWriteEnable_MEM2,
           memRead_MEM1, memRead_MEM2, memWrite_MEM1, memWrite_MEM2,
           result_MEM1, result_MEM2, registerRT_MEM1, registerRT_MEM2,
           storeData_MEM1, storeData_MEM2,
    output stall_MEM, result_WB1, result_WB2, registerRT_WB1, registerRT_WB2,
           regWriteEnable_WB1, regWriteEnable_WB2, ls_err
  );

endinterface

// File: rtl/mem_stage_ls_ram.sv
// Single-port quadword local store: synchronous write, synchronous read-before-write.
module ls_ram
  import spu_pkg::*;
#(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [QW_W-1:0]   wdata,
  output logic [QW_W-1:0]   rdata
);

  logic [QW_W-1:0] mem_q [DEPTH];
  logic [QW_W-1:0] rdata_q;

  // Read data reflects the contents before any write on the same edge.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_stage_ls.sv
// Dual-lane MEM stage servicing loads/stores against the local store; serialises
// same-cycle memory ops over two cycles. Optional range checking under LS_ERR_EN.
module mem_stage_ls
  import spu_pkg::*;
#(
  parameter int LS_DEPTH = 2048,
  parameter int ADDR_W   = $clog2(LS_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  mem_stage_ls_if.slave ls
);

  ls_state_t         state_q, state_d;
  wb_lane_t          wb1_q, wb1_d, wb2_q, wb2_d;
  logic              ld_sel1_q, ld_sel1_d, ld_sel2_q, ld_sel2_d;
  logic              mem_op1, mem_op2, dual_op, use_lane2;
  logic              lane_oor1, lane_oor2;
  logic              port_en, port_we, port_oor;
  logic [ADDR_W-1:0] port_idx;
  logic [QW_W-1:0]   port_wdata, ram_rdata;

  always_comb begin
    mem_op1 = ls.memRead_MEM1 | ls.memWrite_MEM1;
    mem_op2 = ls.memRead_MEM2 | ls.memWrite_MEM2;
    dual_op = mem_op1 & mem_op2;
`ifdef LS_ERR_EN
    lane_oor1 = mem_op1 & addr_oor(ls.result_MEM1[QW_W-1 -: BYTE_ADDR_W], ADDR_W);
    lane_oor2 = mem_op2 & addr_oor(ls.result_MEM2[QW_W-1 -: BYTE_ADDR_W], ADDR_W);
`else
    lane_oor1 = 1'b0;
    lane_oor2 = 1'b0;
`endif

    // The single array port goes to lane 2 in SECOND, or when lane 1 has no memory op.
    use_lane2  = (state_q == SECOND) || !mem_op1;
    port_en    = ((state_q == SECOND) ? mem_op2 : (mem_op1 | mem_op2)) & reset;
    port_we    = use_lane2 ? ls.memWrite_MEM2 : ls.memWrite_MEM1;
    port_oor   = use_lane2 ? lane_oor2 : lane_oor1;
    port_wdata = use_lane2 ? ls.storeData_MEM2 : ls.storeData_MEM1;
    port_idx   = use_lane2 ? ls.result_MEM2[96+ADDR_W+3:100]
                           : ls.result_MEM1[96+ADDR_W+3:100];

    wb1_d     = '0;
    wb2_d     = '0;
    ld_sel1_d = 1'b0;
    ld_sel2_d = 1'b0;
    // Load data arrives from the array after the edge, so only the mux select is registered.
    if (state_q == IDLE) begin
      wb1_d.rt     = ls.registerRT_MEM1;
      wb1_d.we     = ls.regWriteEnable_MEM1;
      wb1_d.result = ls.memToReg_MEM1 ? '0 : ls.result_MEM1;
      ld_sel1_d    = ls.memToReg_MEM1 & ~lane_oor1;
    end
    if ((state_q == SECOND) || !dual_op) begin
      wb2_d.rt     = ls.registerRT_MEM2;
      wb2_d.we     = ls.regWriteEnable_MEM2;
      wb2_d.result = ls.memToReg_MEM2 ? '0 : ls.result_MEM2;
      ld_sel2_d    = ls.memToReg_MEM2 & ~lane_oor2;
    end

    state_d = IDLE;
    if ((state_q == IDLE) && dual_op) begin
      state_d = SECOND;
    end
  end

  ls_ram #(
    .DEPTH  (LS_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (port_en & ~port_oor),
    .we    (port_we),
    .addr  (port_idx),
    .wdata (port_wdata),
    .rdata (ram_rdata)
  );

`ifdef LS_ERR_EN
  logic ls_err_q, ls_err_d;

  assign ls_err_d  = ls_err_q | (port_en & port_oor);
  assign ls.ls_err = ls_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ls_err_q <= 1'b0;
    end else begin
      ls_err_q <= ls_err_d;
    end
  end
`else
  assign ls.ls_err = 1'b0;
`endif

  // FSM state and MEM/WB registers; reset drops any pending SECOND access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wb1_q     <= '0;
      wb2_q     <= '0;
      ld_sel1_q <= 1'b0;
      ld_sel2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb1_q     <= wb1_d;
      wb2_q     <= wb2_d;
      ld_sel1_q <= ld_sel1_d;
      ld_sel2_q <= ld_sel2_d;
    end
  end

  assign ls.stall_MEM          = (state_q == IDLE) & dual_op & reset;
  assign ls.result_WB1         = ld_sel1_q ? ram_rdata : wb1_q.result;
  assign ls.result_WB2         = ld_sel2_q ? ram_rdata : wb2_q.result;
  assign ls.registerRT_WB1     = wb1_q.rt;
  assign ls.registerRT_WB2     = wb2_q.rt;
  assign ls.regWriteEnable_WB1 = wb1_q.we;
  assign ls.regWriteEnable_WB2 = wb2_q.we;

endmodule

// File: tb/tb_mem_stage_ls.sv
// Self-checking bench for mem_stage_ls: transaction-level local-store model plus
// directed vectors; expectations follow LS_ERR_EN when it is defined.
module tb_mem_stage_ls;

  localparam int LS_DEPTH = 2048;

  typedef struct packed {
    logic         mr;
    logic         mw;
    logic         m2r;
    logic         we;
    logic [31:0]  addr;
    logic [127:0] res;
    logic [6:0]   rt;
    logic [127:0] sd;
  } op_t;

  typedef struct packed {
    logic [127:0] res;
    logic [6:0]   rt;
    logic         we;
  } wb_t;

  localparam wb_t BUBBLE = '0;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic cmp_en;

  logic         exp_stall;
  wb_t          exp_wb1, exp_wb2;
  logic         exp_err;
  logic         model_err;
  logic [127:0] model_mem [LS_DEPTH];

  mem_stage_ls_if ls_if ();

  mem_stage_ls #(.LS_DEPTH(LS_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .ls    (ls_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic op_t nop_op();
    return '0;
  endfunction

  function automatic op_t st_op(input logic [31:0] a, input logic [127:0] d);
    op_t o = '0;
    o.mw = 1'b1; o.addr = a; o.res = {a, 96'h0}; o.sd = d;
    return o;
  endfunction

  function automatic op_t ld_op(input logic [31:0] a, input logic [6:0] rt);
    op_t o = '0;
    o.mr = 1'b1; o.m2r = 1'b1; o.we = 1'b1; o.addr = a; o.res = {a, 96'h0}; o.rt = rt;
    return o;
  endfunction

  function automatic op_t rmw_op(input logic [31:0] a, input logic [127:0] d, input logic [6:0] rt);
    op_t o = ld_op(a, rt);
    o.mw = 1'b1; o.sd = d;
    return o;
  endfunction

  function automatic op_t alu_op(input logic [127:0] r, input logic [6:0] rt);
    op_t o = '0;
    o.we = 1'b1; o.res = r; o.rt = rt;
    return o;
  endfunction

  task automatic drive(input op_t o1, input op_t o2);
    ls_if.memRead_MEM1 = o1.mr;        ls_if.memRead_MEM2 = o2.mr;
    ls_if.memWrite_MEM1 = o1.mw;       ls_if.memWrite_MEM2 = o2.mw;
    ls_if.memToReg_MEM1 = o1.m2r;      ls_if.memToReg_MEM2 = o2.m2r;
    ls_if.regWriteEnable_MEM1 = o1.we; ls_if.regWriteEnable_MEM2 = o2.we;
    ls_if.result_MEM1 = o1.res;        ls_if.result_MEM2 = o2.res;
    ls_if.registerRT_MEM1 = o1.rt;     ls_if.registerRT_MEM2 = o2.rt;
    ls_if.storeData_MEM1 = o1.sd;      ls_if.storeData_MEM2 = o2.sd;
  endtask

  // Retire one lane instruction against the model store, in program order.
  task automatic lane_model(input op_t o, output wb_t w);
    logic [127:0] rd;
    logic         oor;
    int           idx;
    w.res = o.res; w.rt = o.rt; w.we = o.we;
    if (o.mr || o.mw) begin
      idx = int'((o.addr >> 4) % LS_DEPTH);
      oor = 1'b0;
`ifdef LS_ERR_EN
      oor = (o.addr >= 32'(LS_DEPTH * 16));
`endif
      if (oor) begin
        model_err = 1'b1;
        rd = '0;
      end else begin
        rd = model_mem[idx];
        if (o.mw) model_mem[idx] = o.sd;
      end
      if (o.m2r) w.res = rd;
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input logic e_stall, input wb_t e1, input wb_t e2, input logic e_err);
    chk("stall_MEM", 128'(ls_if.stall_MEM), 128'(e_stall));
    chk("result_WB1", ls_if.result_WB1, e1.res);
    chk("registerRT_WB1", 128'(ls_if.registerRT_WB1), 128'(e1.rt));
    chk("regWriteEnable_WB1", 128'(ls_if.regWriteEnable_WB1), 128'(e1.we));
    chk("result_WB2", ls_if.result_WB2, e2.res);
    chk("registerRT_WB2", 128'(ls_if.registerRT_WB2), 128'(e2.rt));
    chk("regWriteEnable_WB2", 128'(ls_if.regWriteEnable_WB2), 128'(e2.we));
    chk("ls_err", 128'(ls_if.ls_err), 128'(e_err));
  endtask

  // Compare process: every cycle outside reset, mid-cycle away from the edge.
  always @(negedge clk) begin
    if (cmp_en) checkOutput(exp_stall, exp_wb1, exp_wb2, exp_err);
  end

  // Issue one pair of lane instructions; a dual memory pair takes two cycles.
  task automatic applyStimulus(input op_t o1, input op_t o2);
    wb_t  p1, p2;
    logic dual;
    dual = (o1.mr || o1.mw) && (o2.mr || o2.mw);
    drive(o1, o2);
    exp_stall = dual;
    lane_model(o1, p1);
    if (dual) p2 = BUBBLE;
    else lane_model(o2, p2);
    @(posedge clk); #1;
    exp_wb1 = p1; exp_wb2 = p2; exp_err = model_err;
    if (dual) begin
      exp_stall = 1'b0;
      p1 = BUBBLE;
      lane_model(o2, p2);
      @(posedge clk); #1;
      exp_wb1 = p1; exp_wb2 = p2; exp_err = model_err;
    end
  endtask

  initial begin
    wb_t p1;
    checks = 0; errors = 0; cmp_en = 1'b0;
    model_err = 1'b0;
    exp_stall = 1'b0; exp_wb1 = BUBBLE; exp_wb2 = BUBBLE; exp_err = 1'b0;
    reset = 1'b0;
    drive(nop_op(), nop_op());
    repeat (2) @(posedge clk);
    #1;
    checkOutput(1'b0, BUBBLE, BUBBLE, 1'b0);
    reset = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    $display("[TB] store then load on the other lane");
    applyStimulus(st_op(32'h10, {16{8'hA5}}), nop_op());
    applyStimulus(nop_op(), ld_op(32'h1C, 7'd5));
    chk("lit load A5", ls_if.result_WB2, {16{8'hA5}});
    chk("lit load rt5", 128'(ls_if.registerRT_WB2), 128'(5));

    $display("[TB] dual pair store/load same address");
    applyStimulus(st_op(32'h20, {8{16'h1111}}), ld_op(32'h20, 7'd6));
    chk("lit dual WB2", ls_if.result_WB2, {8{16'h1111}});
    chk("lit dual WB1 bubble", 128'(ls_if.regWriteEnable_WB1), 128'(0));

    $display("[TB] ALU lane alongside load");
    applyStimulus(alu_op(128'h7, 7'd3), ld_op(32'h10, 7'd4));
    chk("lit alu WB1", ls_if.result_WB1, 128'h7);
    chk("lit alu rt3", 128'(ls_if.registerRT_WB1), 128'(3));
    chk("lit alu WB2", ls_if.result_WB2, {16{8'hA5}});

    $display("[TB] store/store ordering");
    applyStimulus(st_op(32'h30, {16{8'hAA}}), st_op(32'h30, {16{8'hBB}}));
    applyStimulus(ld_op(32'h30, 7'd7), nop_op());
    chk("lit store order", ls_if.result_WB1, {16{8'hBB}});

    $display("[TB] back-to-back dual pairs");
    applyStimulus(ld_op(32'h10, 7'd1), ld_op(32'h20, 7'd2));
    applyStimulus(ld_op(32'h30, 7'd3), ld_op(32'h1C, 7'd4));

    $display("[TB] read-before-write");
    applyStimulus(rmw_op(32'h10, {16{8'hC3}}, 7'd8), nop_op());
    chk("lit rbw old", ls_if.result_WB1, {16{8'hA5}});
    applyStimulus(ld_op(32'h10, 7'd9), nop_op());
    chk("lit rbw new", ls_if.result_WB1, {16{8'hC3}});

    $display("[TB] reset during SECOND");
    applyStimulus(st_op(32'h40, {4{32'h0BAD_F00D}}), nop_op());
    drive(st_op(32'h50, {4{32'h5050_5050}}), st_op(32'h40, {4{32'hDEAD_BEEF}}));
    lane_model(st_op(32'h50, {4{32'h5050_5050}}), p1);
    exp_stall = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput(1'b0, BUBBLE, BUBBLE, 1'b0);
    model_err = 1'b0;
    drive(nop_op(), nop_op());
    @(posedge clk); #1;
    reset = 1'b1;
    exp_stall = 1'b0; exp_wb1 = BUBBLE; exp_wb2 = BUBBLE; exp_err = 1'b0;
    cmp_en = 1'b1;
    applyStimulus(ld_op(32'h40, 7'd11), nop_op());
    chk("lit reset drop", ls_if.result_WB1, {4{32'h0BAD_F00D}});
    applyStimulus(ld_op(32'h50, 7'd12), nop_op());
    chk("lit lane1 kept", ls_if.result_WB1, {4{32'h5050_5050}});

    $display("[TB] address above the local store");
    applyStimulus(st_op(32'h0, {16{8'h5A}}), nop_op());
    applyStimulus(nop_op(), st_op(32'h0001_0000, {16{8'h3C}}));
    applyStimulus(ld_op(32'h0, 7'd10), nop_op());
`ifdef LS_ERR_EN
    chk("lit oor suppressed", ls_if.result_WB1, {16{8'h5A}});
    chk("lit ls_err set", 128'(ls_if.ls_err), 128'(1));
    applyStimulus(ld_op(32'h0001_0000, 7'd13), nop_op());
    chk("lit oor load zero", ls_if.result_WB1, 128'h0);
`else
    chk("lit wrap store", ls_if.result_WB1, {16{8'h3C}});
    chk("lit ls_err tied", 128'(ls_if.ls_err), 128'(0));
`endif

    applyStimulus(nop_op(), nop_op());
    applyStimulus(nop_op(), nop_op());
    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
